// File: rtl/gpio_led_sequencer.sv
// Bus-side mux between the CPU and an autonomous LED sequencer for the gpio block.
// The sequencer plays breathe/chase patterns into LED regs 6..9 and only uses cycles the CPU leaves idle.
module gpio_led_sequencer #(
  parameter int PERIOD_W       = 24,
  parameter int DEFAULT_PERIOD = 1000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_req,
  input  logic [3:0]  cpu_a,
  input  logic [31:0] cpu_d,
  input  logic        cpu_we,
  output logic [31:0] cpu_spo,
  input  logic [1:0]  cfg_a,
  input  logic [31:0] cfg_d,
  input  logic        cfg_we,
  output logic [31:0] cfg_spo,
  output logic [3:0]  gpio_a,
  output logic [31:0] gpio_d,
  output logic        gpio_we,
  input  logic [31:0] gpio_spo
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    WR0  = 3'd4,
    WR1  = 3'd5,
    WR2  = 3'd6,
    WR3  = 3'd7
  } state_t;

  state_t              state;
  logic                en;
  logic                mode;
  logic                dir;
  logic                ovr;
  logic [PERIOD_W-1:0] period;
  logic [PERIOD_W-1:0] cnt;
  logic [PERIOD_W-1:0] period_m1;
  logic [3:0]          lvl;
  logic [1:0]          pos;
  logic [15:0]         vals;
  logic                terminal;

  logic [3:0]          nxt_lvl;
  logic                nxt_dir;
  logic [1:0]          nxt_pos;
  logic [15:0]         nxt_vals;

  logic [1:0]          wr_idx;
  logic                seq_we;
  logic [3:0]          seq_a;
  logic [3:0]          seq_val;
  logic                cfg_unused;

  // A zero period behaves like a period of one: a tick every WAIT cycle.
  assign period_m1 = (period == '0) ? '0 : period - 1'b1;
  assign terminal  = cnt >= period_m1;

  always_comb begin
    nxt_lvl  = lvl;
    nxt_dir  = dir;
    nxt_pos  = pos;
    nxt_vals = vals;
    if (!mode) begin
      if (dir) begin
        nxt_lvl = lvl + 4'd1;
        if (nxt_lvl == 4'd15) nxt_dir = 1'b0;
      end else begin
        nxt_lvl = lvl - 4'd1;
        if (nxt_lvl == 4'd0) nxt_dir = 1'b1;
      end
      nxt_vals = {4{nxt_lvl}};
    end else begin
      nxt_pos = pos + 2'd1;
      for (int k = 0; k < 4; k++)
        nxt_vals[4*k +: 4] = (nxt_pos == 2'(k)) ? 4'hF : 4'h0;
    end
  end

  // Sequencer writes are gated by en so a disable aborts the rest of the frame at once.
  assign wr_idx  = state[1:0];
  assign seq_we  = en && state[2];
  assign seq_a   = 4'd6 + {2'b00, wr_idx};
  assign seq_val = vals[{wr_idx, 2'b00} +: 4];

  assign gpio_a  = cpu_req ? cpu_a  : seq_a;
  assign gpio_d  = cpu_req ? cpu_d  : {4'b0, seq_val, 24'b0};
  assign gpio_we = cpu_req ? cpu_we : seq_we;
  assign cpu_spo = gpio_spo;

  assign cfg_unused = ^cfg_d;

  always_comb begin
    cfg_spo = '0;
    case (cfg_a)
      2'd0:    cfg_spo = {30'b0, mode, en};
      2'd1:    cfg_spo[PERIOD_W-1:0] = period;
      2'd2:    cfg_spo = {23'b0, ovr, state, lvl, dir};
      default: cfg_spo = '0;
    endcase
  end

  // Config writes come first so an overrun in the same cycle as a clear still sticks.
  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      en     <= 1'b0;
      mode   <= 1'b0;
      period <= PERIOD_W'(DEFAULT_PERIOD);
      cnt    <= '0;
      lvl    <= 4'd0;
      dir    <= 1'b1;
      pos    <= 2'd0;
      vals   <= '0;
      ovr    <= 1'b0;
    end else begin
      if (cfg_we) begin
        case (cfg_a)
          2'd0: begin
            en   <= cfg_d[0];
            mode <= cfg_d[1];
          end
          2'd1:    period <= cfg_d[PERIOD_W-1:0];
          2'd3:    ovr    <= 1'b0;
          default: ;
        endcase
      end
      if (!en) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            cnt   <= '0;
            state <= WAIT;
          end
          WAIT: begin
            if (terminal) begin
              cnt   <= '0;
              lvl   <= nxt_lvl;
              dir   <= nxt_dir;
              pos   <= nxt_pos;
              vals  <= nxt_vals;
              state <= WR0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          WR0, WR1, WR2, WR3: begin
            if (terminal) begin
              ovr <= 1'b1;
              cnt <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
            if (!cpu_req) begin
              case (state)
                WR0:     state <= WR1;
                WR1:     state <= WR2;
                WR2:     state <= WR3;
                default: state <= WAIT;
              endcase
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_gpio_led_sequencer.sv
// Randomized and directed bench for gpio_led_sequencer against a frame-level behavioural model.
module tb_gpio_led_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req;
  logic [3:0]  cpu_a;
  logic [31:0] cpu_d;
  logic        cpu_we;
  logic [31:0] cpu_spo;
  logic [1:0]  cfg_a;
  logic [31:0] cfg_d;
  logic        cfg_we;
  logic [31:0] cfg_spo;
  logic [3:0]  gpio_a;
  logic [31:0] gpio_d;
  logic        gpio_we;
  logic [31:0] gpio_spo;

  int checks = 0;
  int errors = 0;

  gpio_led_sequencer dut (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_a(cpu_a), .cpu_d(cpu_d), .cpu_we(cpu_we), .cpu_spo(cpu_spo),
    .cfg_a(cfg_a), .cfg_d(cfg_d), .cfg_we(cfg_we), .cfg_spo(cfg_spo),
    .gpio_a(gpio_a), .gpio_d(gpio_d), .gpio_we(gpio_we), .gpio_spo(gpio_spo)
  );

  always #5 clk = ~clk;

  // Model: phase -1 idle, 0 waiting, 1..4 writing LED k=phase-1; patterns derive from frame counts.
  bit          m_en, m_mode, m_ovr;
  int unsigned m_period, m_cnt;
  int          m_bn, m_cn, m_phase;
  int          m_vals[4];
  logic [3:0]  e_a;
  logic [31:0] e_d, e_cfg;
  logic        e_we;
  bit          e_chk_ad;

  function automatic int tri_lvl(input int n);
    int r = n % 30;
    return (r <= 15) ? r : 30 - r;
  endfunction

  function automatic bit tri_dir(input int n);
    return (n % 30) < 15;
  endfunction

  function automatic int state_code();
    if (m_phase < 0) return 0;
    if (m_phase == 0) return 1;
    return 3 + m_phase;
  endfunction

  task automatic model_reset();
    m_en = 0; m_mode = 0; m_ovr = 0; m_period = 1000000; m_cnt = 0;
    m_bn = 0; m_cn = 0; m_phase = -1;
    for (int k = 0; k < 4; k++) m_vals[k] = 0;
  endtask

  task automatic model_comb();
    e_chk_ad = 1;
    if (cpu_req) begin
      e_a = cpu_a; e_d = cpu_d; e_we = cpu_we;
    end else if (m_en && m_phase >= 1) begin
      e_a = 4'(5 + m_phase); e_d = 32'(m_vals[m_phase-1]) << 24; e_we = 1'b1;
    end else begin
      e_a = 4'd0; e_d = 32'd0; e_we = 1'b0; e_chk_ad = 0;
    end
    case (cfg_a)
      2'd0:    e_cfg = {30'b0, m_mode, m_en};
      2'd1:    e_cfg = m_period;
      2'd2:    e_cfg = {23'b0, m_ovr, 3'(state_code()), 4'(tri_lvl(m_bn)), tri_dir(m_bn)};
      default: e_cfg = 32'd0;
    endcase
  endtask

  task automatic model_seq();
    bit set_ovr = 0;
    bit term;
    int unsigned pm1;
    if (rst) begin
      model_reset();
      return;
    end
    pm1  = (m_period == 0) ? 0 : m_period - 1;
    term = m_cnt >= pm1;
    if (!m_en) begin
      m_phase = -1; m_cnt = 0;
    end else if (m_phase < 0) begin
      m_phase = 0; m_cnt = 0;
    end else if (m_phase == 0) begin
      if (term) begin
        m_cnt = 0; m_phase = 1;
        if (!m_mode) begin
          m_bn++;
          for (int k = 0; k < 4; k++) m_vals[k] = tri_lvl(m_bn);
        end else begin
          m_cn++;
          for (int k = 0; k < 4; k++) m_vals[k] = (k == m_cn % 4) ? 15 : 0;
        end
      end else m_cnt++;
    end else begin
      if (term) begin set_ovr = 1; m_cnt = 0; end
      else m_cnt++;
      if (!cpu_req) m_phase = (m_phase == 4) ? 0 : m_phase + 1;
    end
    if (cfg_we) begin
      case (cfg_a)
        2'd0: begin m_en = cfg_d[0]; m_mode = cfg_d[1]; end
        2'd1: m_period = cfg_d[23:0];
        2'd3: m_ovr = 0;
        default: ;
      endcase
    end
    if (set_ovr) m_ovr = 1;
  endtask

  task automatic settle();
    #1;
    model_comb();
  endtask

  task automatic clock_edge();
    @(posedge clk);
    model_seq();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    cpu_req = 0; cpu_we = 0; cpu_a = 0; cpu_d = 0;
    cfg_we = 0; cfg_a = 0; cfg_d = 0; gpio_spo = $urandom;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    settle(); clock_edge(); clock_edge();
    rst = 0;
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [31:0] d);
    cfg_we = 1; cfg_a = a; cfg_d = d;
    settle(); clock_edge();
    cfg_we = 0;
  endtask

  task automatic wait_phase(input int ph, output bit found);
    found = 0;
    for (int i = 0; i < 200; i++) begin
      settle();
      if (m_phase == ph) begin found = 1; break; end
      clock_edge();
    end
  endtask

  task automatic test_reset();
    logic [31:0] exp_cfg[4];
    exp_cfg[0] = 32'd0; exp_cfg[1] = 32'd1000000; exp_cfg[2] = 32'h1; exp_cfg[3] = 32'd0;
    do_reset();
    for (int a = 0; a < 4; a++) begin
      cfg_a = 2'(a); settle();
      checks++;
      if (cfg_spo !== exp_cfg[a]) begin
        errors++; $display("[TB] FAIL reset_cfg%0d got %h want %h", a, cfg_spo, exp_cfg[a]);
      end
    end
    checks++;
    if (gpio_we !== 1'b0 || cpu_spo !== gpio_spo) begin
      errors++; $display("[TB] FAIL reset_idle we %b spo %h want 0 %h", gpio_we, cpu_spo, gpio_spo);
    end
    cpu_req = 1; cpu_we = 1; cpu_a = 4'd5; cpu_d = $urandom; settle();
    checks++;
    if ({gpio_a, gpio_d, gpio_we} !== {cpu_a, cpu_d, 1'b1}) begin
      errors++; $display("[TB] FAIL reset_cpu_pass got %h/%h/%b want %h/%h/1", gpio_a, gpio_d, gpio_we, cpu_a, cpu_d);
    end
    idle_inputs();
  endtask

  task automatic test_breathe();
    logic [7:0] wq[$];
    int first = -1;
    int v;
    do_reset();
    cfg_write(2'd1, 32'd4);
    cfg_write(2'd0, 32'd1);
    cfg_a = 2'd2;
    for (int i = 0; i < 400 && wq.size() < 124; i++) begin
      settle();
      checks++;
      if (gpio_we !== e_we || cfg_spo !== e_cfg) begin
        errors++; $display("[TB] FAIL breathe_cycle%0d we %b status %h want %b %h", i, gpio_we, cfg_spo, e_we, e_cfg);
      end
      if (gpio_we) begin
        if (first < 0) first = i;
        wq.push_back({gpio_a, gpio_d[27:24]});
      end
      clock_edge();
    end
    checks++;
    if (first != 5) begin
      errors++; $display("[TB] FAIL breathe_latency got %0d want 5", first);
    end
    checks++;
    if (wq.size() != 124) begin
      errors++; $display("[TB] FAIL breathe_count got %0d want 124", wq.size());
    end
    for (int i = 0; i < wq.size(); i++) begin
      v = i / 4 + 1;
      v = (v <= 15) ? v : ((v <= 30) ? 30 - v : v - 30);
      checks++;
      if (wq[i] !== {4'(6 + i % 4), 4'(v)}) begin
        errors++; $display("[TB] FAIL breathe_write%0d got %h want %h", i, wq[i], {4'(6 + i % 4), 4'(v)});
      end
    end
    settle();
    checks++;
    if (cfg_spo[4:0] !== 5'b00011) begin
      errors++; $display("[TB] FAIL breathe_status_lvl_dir got %b want 00011", cfg_spo[4:0]);
    end
  endtask

  task automatic test_chase();
    logic [7:0] wq[$];
    int p;
    do_reset();
    cfg_write(2'd1, 32'd4);
    cfg_write(2'd0, 32'd3);
    for (int i = 0; i < 200 && wq.size() < 16; i++) begin
      settle();
      if (gpio_we) wq.push_back({gpio_a, gpio_d[27:24]});
      clock_edge();
    end
    checks++;
    if (wq.size() != 16) begin
      errors++; $display("[TB] FAIL chase_count got %0d want 16", wq.size());
    end
    for (int i = 0; i < wq.size(); i++) begin
      p = (i / 4 + 1) % 4;
      checks++;
      if (wq[i] !== {4'(6 + i % 4), ((i % 4) == p) ? 4'hF : 4'h0}) begin
        errors++; $display("[TB] FAIL chase_write%0d got %h want pos %0d", i, wq[i], p);
      end
    end
  endtask

  task automatic test_cpu_stall();
    bit found;
    do_reset();
    cfg_write(2'd1, 32'd20);
    cfg_write(2'd0, 32'd1);
    wait_phase(2, found);
    checks++;
    if (!found) begin errors++; $display("[TB] FAIL stall_wait got timeout want WR1"); end
    for (int i = 0; i < 3; i++) begin
      cpu_req = 1; cpu_a = 4'd6; cpu_we = 1; cpu_d = 32'h0900_0000; cfg_a = 2'd2;
      settle();
      checks++;
      if ({gpio_a, gpio_d, gpio_we} !== {4'd6, 32'h0900_0000, 1'b1} || cfg_spo[7:5] !== 3'd5) begin
        errors++; $display("[TB] FAIL stall_cpu%0d got %h/%h/%b st %0d want 6/09000000/1 st 5", i, gpio_a, gpio_d, gpio_we, cfg_spo[7:5]);
      end
      clock_edge();
    end
    idle_inputs();
    for (int k = 1; k < 4; k++) begin
      settle();
      checks++;
      if ({gpio_a, gpio_d, gpio_we} !== {4'(6 + k), 32'h0100_0000, 1'b1}) begin
        errors++; $display("[TB] FAIL stall_resume%0d got %h/%h/%b want %0d/01000000/1", k, gpio_a, gpio_d, gpio_we, 6 + k);
      end
      clock_edge();
    end
  endtask

  task automatic test_overrun();
    bit found;
    do_reset();
    cfg_write(2'd1, 32'd2);
    cfg_write(2'd0, 32'd1);
    wait_phase(1, found);
    cfg_a = 2'd2; settle();
    checks++;
    if (!found || cfg_spo[8] !== 1'b0) begin
      errors++; $display("[TB] FAIL ovr_before got found %b ovr %b want 1 0", found, cfg_spo[8]);
    end
    for (int i = 0; i < 10; i++) begin
      cpu_req = 1; cpu_we = 0; cpu_a = 4'($urandom); cpu_d = $urandom;
      settle();
      checks++;
      if (gpio_we !== 1'b0 || gpio_a !== cpu_a) begin
        errors++; $display("[TB] FAIL ovr_cpu%0d got we %b a %h want 0 %h", i, gpio_we, gpio_a, cpu_a);
      end
      clock_edge();
    end
    cpu_req = 0; settle();
    checks++;
    if (cfg_spo[8] !== 1'b1 || cfg_spo[7:5] !== 3'd4) begin
      errors++; $display("[TB] FAIL ovr_set got ovr %b st %0d want 1 4", cfg_spo[8], cfg_spo[7:5]);
    end
    cfg_write(2'd0, 32'd0);
    clock_edge();
    cfg_a = 2'd2; settle();
    checks++;
    if (cfg_spo[8] !== 1'b1 || cfg_spo[7:5] !== 3'd0) begin
      errors++; $display("[TB] FAIL ovr_sticky got ovr %b st %0d want 1 0", cfg_spo[8], cfg_spo[7:5]);
    end
    cfg_write(2'd3, 32'd0);
    cfg_a = 2'd2; settle();
    checks++;
    if (cfg_spo[8] !== 1'b0) begin
      errors++; $display("[TB] FAIL ovr_clear got %b want 0", cfg_spo[8]);
    end
  endtask

  task automatic test_disable_midframe();
    bit found;
    do_reset();
    cfg_write(2'd1, 32'd20);
    cfg_write(2'd0, 32'd1);
    wait_phase(2, found);
    cfg_we = 1; cfg_a = 2'd0; cfg_d = 32'd0;
    settle();
    checks++;
    if (!found || gpio_we !== 1'b1 || gpio_a !== 4'd7) begin
      errors++; $display("[TB] FAIL dis_wr1 got we %b a %0d want 1 7", gpio_we, gpio_a);
    end
    clock_edge();
    cfg_we = 0; cfg_a = 2'd2; settle();
    checks++;
    if (gpio_we !== 1'b0 || cfg_spo[7:5] !== 3'd6) begin
      errors++; $display("[TB] FAIL dis_wr2 got we %b st %0d want 0 6", gpio_we, cfg_spo[7:5]);
    end
    clock_edge();
    settle();
    checks++;
    if (cfg_spo !== 32'h3) begin
      errors++; $display("[TB] FAIL dis_status got %h want 00000003", cfg_spo);
    end
    for (int i = 0; i < 5; i++) begin
      settle();
      checks++;
      if (gpio_we !== 1'b0) begin
        errors++; $display("[TB] FAIL dis_quiet%0d got %b want 0", i, gpio_we);
      end
      clock_edge();
    end
  endtask

  task automatic test_reset_midframe();
    bit found;
    logic [31:0] exp_cfg[4];
    exp_cfg[0] = 32'd0; exp_cfg[1] = 32'd1000000; exp_cfg[2] = 32'h1; exp_cfg[3] = 32'd0;
    do_reset();
    cfg_write(2'd1, 32'd20);
    cfg_write(2'd0, 32'd3);
    wait_phase(3, found);
    rst = 1; settle(); clock_edge(); rst = 0;
    for (int a = 0; a < 4; a++) begin
      cfg_a = 2'(a); cpu_req = 1'(a % 2); cpu_we = 1'(a / 2); cpu_a = 4'($urandom);
      settle();
      checks++;
      if (!found || cfg_spo !== exp_cfg[a] || gpio_we !== (cpu_req & cpu_we)) begin
        errors++; $display("[TB] FAIL rstmid%0d got cfg %h we %b want %h %b", a, cfg_spo, gpio_we, exp_cfg[a], cpu_req & cpu_we);
      end
      clock_edge();
    end
    idle_inputs();
  endtask

  task automatic test_random_traffic(input int n);
    do_reset();
    cfg_write(2'd1, 32'($urandom_range(0, 6)));
    cfg_write(2'd0, 32'd1);
    for (int i = 0; i < n; i++) begin
      cpu_req = ($urandom_range(0, 99) < 25); cpu_we = 1'($urandom);
      cpu_a = 4'($urandom); cpu_d = $urandom; gpio_spo = $urandom;
      cfg_a = 2'($urandom); cfg_we = ($urandom_range(0, 99) < 3);
      case (cfg_a)
        2'd0:    cfg_d = {30'b0, 1'($urandom), 1'($urandom_range(0, 9) != 0)};
        2'd1:    cfg_d = 32'($urandom_range(0, 6));
        default: cfg_d = $urandom;
      endcase
      settle();
      checks++;
      if (gpio_we !== e_we || (e_chk_ad && {gpio_a, gpio_d} !== {e_a, e_d})) begin
        errors++; $display("[TB] FAIL rand_gpio%0d got %h/%h/%b want %h/%h/%b", i, gpio_a, gpio_d, gpio_we, e_a, e_d, e_we);
      end
      checks++;
      if (cfg_spo !== e_cfg || cpu_spo !== gpio_spo) begin
        errors++; $display("[TB] FAIL rand_read%0d got cfg %h spo %h want %h %h", i, cfg_spo, cpu_spo, e_cfg, gpio_spo);
      end
      clock_edge();
    end
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    model_reset();
    @(negedge clk);
    test_reset();
    test_breathe();
    test_chase();
    test_cpu_stall();
    test_overrun();
    test_disable_midframe();
    test_reset_midframe();
    test_random_traffic(3000);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
